sin_pwm_gen: RTL and testbench

- Downstream consumer of the sample strobe `pwm_clk` produced by the prescaler/sample-tick stage.
- Holds a phase accumulator and a quarter-wave sine ROM, and drives an 8-bit PWM output whose duty follows a sine wave.
- Output frequency is set by a frequency tuning word (FTW), loaded through a load/ack handshake.
- FTW loads, duty updates and start/stop all take effect only at PWM period boundaries, so the output never glitches.

---
 rtl/sin_pwm_gen.sv | 225 ++++++++++++++++++++++
 tb/tb_sin_pwm_gen.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sin_pwm_gen.sv
// sin_pwm_gen: sine-modulated PWM generator.
// A phase accumulator addresses a 16-entry quarter-wave sine ROM. The resulting
// 8-bit sample becomes the duty cycle of a 256-cycle PWM period. Duty, FTW loads
// and start/stop all take effect only on period boundaries, so the output never
// glitches mid-period.
//
// FTW handshake: ftw_load is a single-cycle request that carries ftw. The value
// waits in ftw_pend until the next period boundary or run entry. A later load
// overwrites an earlier one that is still waiting. ftw_ack pulses for one cycle
// when the value becomes active.
//
// Optional build macro SIN_PWM_COMPL_EN adds a complementary output, pwm_out_n.
// After every edge of the raw comparison, DEAD cycles with both outputs low are
// inserted.
`timescale 1ns/1ps

module sin_pwm_gen #(
    parameter int PHASE_BITS = 12,
    parameter int DEAD       = 2
) (
    input  logic                  rst,
    input  logic                  pwm_clk,
    input  logic                  en,
    input  logic [PHASE_BITS-1:0] ftw,
    input  logic                  ftw_load,
    output logic                  ftw_ack,
    output logic                  pwm_out,
`ifdef SIN_PWM_COMPL_EN
    output logic                  pwm_out_n,
`endif
    output logic [7:0]            sample,
    output logic                  period_start,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;

    logic [PHASE_BITS-1:0] phase;
    logic [PHASE_BITS-1:0] ftw_act;
    logic [PHASE_BITS-1:0] ftw_pend;
    logic                  pend_flag;
    logic [7:0]            cnt;
    logic [7:0]            duty;

    logic                  active;
    logic                  boundary;
    logic                  start;
    logic                  apply;
    logic                  raw_d;

    logic [1:0]            quad;
    logic [3:0]            idx;
    logic [3:0]            rom_addr;
    logic [6:0]            rom_val;
    logic [7:0]            sample_nxt;

    // The top 6 phase bits are needed to address the ROM. A negative dead time is meaningless.
    if (PHASE_BITS < 6 || DEAD < 0 || DEAD > 254) begin : g_param_guard
        $error("sin_pwm_gen: PHASE_BITS must be >= 6 and DEAD in 0..254");
    end

    // Quarter-wave sine magnitudes. Quadrant folding happens outside the table.
    function automatic logic [6:0] rom_q(input logic [3:0] i);
        case (i)
            4'd0:    rom_q = 7'd6;
            4'd1:    rom_q = 7'd19;
            4'd2:    rom_q = 7'd31;
            4'd3:    rom_q = 7'd43;
            4'd4:    rom_q = 7'd54;
            4'd5:    rom_q = 7'd65;
            4'd6:    rom_q = 7'd76;
            4'd7:    rom_q = 7'd85;
            4'd8:    rom_q = 7'd94;
            4'd9:    rom_q = 7'd102;
            4'd10:   rom_q = 7'd109;
            4'd11:   rom_q = 7'd115;
            4'd12:   rom_q = 7'd120;
            4'd13:   rom_q = 7'd123;
            4'd14:   rom_q = 7'd126;
            4'd15:   rom_q = 7'd127;
            default: rom_q = 7'd0;
        endcase
    endfunction

    // The PWM keeps running in STOP, so both RUN and STOP count as active.
    assign active = (state_q != IDLE);

    // A STOP that is re-armed on its last cycle must roll over exactly like RUN.
    assign boundary = (cnt == 8'd255) && ((state_q == RUN) || ((state_q == STOP) && en));
    assign start    = (state_q == IDLE) && en;
    assign apply    = boundary || start;
    assign raw_d    = active && (cnt < duty);
    assign busy     = active;

    // Fold the phase into a quadrant and an index, then add the signed magnitude to midscale.
    always_comb begin
        quad       = phase[PHASE_BITS-1:PHASE_BITS-2];
        idx        = phase[PHASE_BITS-3:PHASE_BITS-6];
        rom_addr   = quad[0] ? (4'd15 - idx) : idx;
        rom_val    = rom_q(rom_addr);
        sample_nxt = quad[1] ? (8'd128 - {1'b0, rom_val}) : (8'd128 + {1'b0, rom_val});
    end

    // FSM state register.
    always_ff @(posedge pwm_clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state. STOP lets the current period finish before it returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (en) state_d = RUN;
            RUN:  if (!en) state_d = STOP;
            STOP: begin
                if (en) begin
                    state_d = RUN;
                end else if (cnt == 8'd255) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: the sample is refreshed every cycle. Duty and phase move only at boundaries.
    always_ff @(posedge pwm_clk or negedge rst) begin
        if (!rst) begin
            phase        <= '0;
            cnt          <= 8'd0;
            duty         <= 8'd0;
            sample       <= 8'd128;
            period_start <= 1'b0;
        end else begin
            sample       <= sample_nxt;
            cnt          <= active ? (cnt + 8'd1) : 8'd0;
            period_start <= apply;
            if (apply) begin
                duty <= sample;
            end
            if (boundary) begin
                phase <= phase + ftw_act;
            end
        end
    end

    // FTW handshake. A load on the apply cycle bypasses ftw_pend and goes straight into ftw_act.
    always_ff @(posedge pwm_clk or negedge rst) begin
        if (!rst) begin
            ftw_act   <= '0;
            ftw_pend  <= '0;
            pend_flag <= 1'b0;
            ftw_ack   <= 1'b0;
        end else begin
            ftw_ack <= 1'b0;
            if (apply) begin
                if (ftw_load) begin
                    ftw_act <= ftw;
                end else if (pend_flag) begin
                    ftw_act <= ftw_pend;
                end
                ftw_ack   <= ftw_load | pend_flag;
                pend_flag <= 1'b0;
            end else if (ftw_load) begin
                ftw_pend  <= ftw;
                pend_flag <= 1'b1;
            end
        end
    end

`ifdef SIN_PWM_COMPL_EN
    localparam logic [7:0] DEAD_C = 8'(DEAD);

    logic       pwm_raw;
    logic [7:0] run_q;
    logic [7:0] run_nxt;

    // run_nxt counts how long the raw comparison has held its value. It saturates so it cannot wrap.
    always_comb begin
        if (raw_d != pwm_raw) begin
            run_nxt = 8'd0;
        end else if (run_q == 8'hFF) begin
            run_nxt = run_q;
        end else begin
            run_nxt = run_q + 8'd1;
        end
    end

    // An output rises only after the raw level has been stable for DEAD cycles.
    always_ff @(posedge pwm_clk or negedge rst) begin
        if (!rst) begin
            pwm_raw   <= 1'b0;
            run_q     <= 8'd0;
            pwm_out   <= 1'b0;
            pwm_out_n <= 1'b0;
        end else begin
            pwm_raw   <= raw_d;
            run_q     <= run_nxt;
            pwm_out   <= raw_d && (run_nxt >= DEAD_C);
            pwm_out_n <= active && !raw_d && (run_nxt >= DEAD_C);
        end
    end
`else
    // Registered raw comparison. It is forced low in IDLE through raw_d.
    always_ff @(posedge pwm_clk or negedge rst) begin
        if (!rst) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= raw_d;
        end
    end
`endif

endmodule

// File: tb/tb_sin_pwm_gen.sv
// Directed testbench for sin_pwm_gen (PHASE_BITS=12, DEAD=2).
`timescale 1ns/1ps

module tb_sin_pwm_gen;

    localparam int PB   = 12;
    localparam int DEAD = 2;

    logic          rst;
    logic          pwm_clk;
    logic          en;
    logic [PB-1:0] ftw;
    logic          ftw_load;
    logic          ftw_ack;
    logic          pwm_out;
    logic [7:0]    sample;
    logic          period_start;
    logic          busy;
`ifdef SIN_PWM_COMPL_EN
    logic          pwm_out_n;
`endif

    int         n_checks = 0;
    int         n_pass   = 0;
    int         ack_cnt  = 0;
    logic [7:0] exp_q[$];

    sin_pwm_gen #(.PHASE_BITS(PB), .DEAD(DEAD)) dut (
        .rst          (rst),
        .pwm_clk      (pwm_clk),
        .en           (en),
        .ftw          (ftw),
        .ftw_load     (ftw_load),
        .ftw_ack      (ftw_ack),
        .pwm_out      (pwm_out),
`ifdef SIN_PWM_COMPL_EN
        .pwm_out_n    (pwm_out_n),
`endif
        .sample       (sample),
        .period_start (period_start),
        .busy         (busy)
    );

    // Clock and reset.
    initial begin
        pwm_clk = 1'b0;
        forever #5 pwm_clk = ~pwm_clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one cycle. Sampling happens on the falling edge. Every ack pulse is counted here.
    task automatic tick();
        @(negedge pwm_clk);
        if (ftw_ack) ack_cnt++;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        en       = 1'b0;
        ftw_load = 1'b0;
        ftw      = '0;
        repeat (3) @(negedge pwm_clk);
        rst     = 1'b1;
        ack_cnt = 0;
    endtask

    task automatic load_ftw(input logic [PB-1:0] v);
        ftw      = v;
        ftw_load = 1'b1;
        tick();
        ftw_load = 1'b0;
    endtask

    task automatic wait_ps(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (period_start) break;
            tick();
        end
        check(tag, period_start, 1);
    endtask

    // Call on a period_start cycle. The call returns on the next period_start cycle.
    // It returns the number of high cycles and the mid-period sample.
    task automatic measure(output int hi, output int smp);
        hi  = 0;
        smp = 0;
        for (int i = 0; i < 256; i++) begin
            hi += int'(pwm_out);
            if (i == 128) smp = int'(sample);
            tick();
        end
    endtask

    initial begin
        int hi;
        int smp;
        int ack0;
        int busy_lo;

        // Reset values while rst is held low.
        rst      = 1'b0;
        en       = 1'b0;
        ftw_load = 1'b0;
        ftw      = '0;
        repeat (2) @(negedge pwm_clk);
        check("rst_sample", sample, 128);
        check("rst_pwm", pwm_out, 0);
        check("rst_busy", busy, 0);
        check("rst_ps", period_start, 0);
        check("rst_ack", ftw_ack, 0);
        rst     = 1'b1;
        ack_cnt = 0;

        // No FTW loaded. Phase 0 maps to ROM entry 0, so the sample is 128+6.
        repeat (3) tick();
        check("t1_sample_idle", sample, 134);
        check("t1_busy_idle", busy, 0);
        en = 1'b1;
        tick();
        check("t1_ps_entry", period_start, 1);
        check("t1_busy_run", busy, 1);
        check("t1_no_ack", ftw_ack, 0);
        measure(hi, smp);
        check("t1_hi_p1", hi, 134);
        check("t1_ps_p2", period_start, 1);
        measure(hi, smp);
        check("t1_hi_p2", hi, 134);
        check("t1_smp_p2", smp, 134);

        // FTW=64 loaded in IDLE. Each period advances one ROM index.
        do_reset();
        load_ftw(12'd64);
        repeat (3) tick();
        check("t2_no_ack_idle", ftw_ack, 0);
        en = 1'b1;
        tick();
        check("t2_ack_entry", ftw_ack, 1);
        check("t2_ps_entry", period_start, 1);
        exp_q = '{8'd134, 8'd147, 8'd159, 8'd171, 8'd182, 8'd193, 8'd204, 8'd213, 8'd222,
                  8'd230, 8'd237, 8'd243, 8'd248, 8'd251, 8'd254, 8'd255, 8'd255, 8'd254};
        for (int k = 1; k <= 49; k++) begin
            measure(hi, smp);
            if (k <= 18) check($sformatf("t2_smp_p%0d", k), smp, exp_q.pop_front());
            // Duty trails the mid-period sample by one period.
            if (k == 2)  check("t2_hi_p2", hi, 134);
            if (k == 3)  check("t2_hi_p3", hi, 147);
            if (k == 33) check("t2_smp_p33", smp, 122);
            if (k == 49) check("t2_smp_p49_trough", smp, 1);
            if (k == 49) check("t2_hi_p49_min", hi, 1);
        end
        check("t2_single_ack", ack_cnt, 1);

        // Two mid-period loads. Only the last one is kept, and one ack follows at the boundary.
        ack0 = ack_cnt;
        repeat (100) tick();
        load_ftw(12'd10);
        repeat (20) tick();
        load_ftw(12'd20);
        wait_ps("t3_ps");
        check("t3_ack_at_boundary", ftw_ack, 1);
        check("t3_ack_count", ack_cnt - ack0, 1);
        check("t3_ftw_act", dut.ftw_act, 20);
        // A load on the boundary cycle itself goes straight into ftw_act.
        repeat (255) tick();
        ftw      = 12'd7;
        ftw_load = 1'b1;
        tick();
        ftw_load = 1'b0;
        check("t3_bypass_ps", period_start, 1);
        check("t3_bypass_ack", ftw_ack, 1);
        check("t3_bypass_ftw_act", dut.ftw_act, 7);
        check("t3_bypass_ack_count", ack_cnt - ack0, 2);

        // Stop request at cnt=100. The period completes, then the block idles with phase held.
        do_reset();
        load_ftw(12'd64);
        en = 1'b1;
        tick();
        measure(hi, smp);
        check("t4_ps_p2", period_start, 1);
        hi      = 0;
        busy_lo = 0;
        for (int i = 0; i < 256; i++) begin
            hi += int'(pwm_out);
            busy_lo += int'(!busy);
            if (i == 100) en = 1'b0;
            tick();
        end
        check("t4_stop_hi", hi, 134);
        check("t4_stop_busy_gap", busy_lo, 0);
        check("t4_idle_busy", busy, 0);
        check("t4_idle_pwm", pwm_out, 0);
        check("t4_idle_ps", period_start, 0);
        repeat (5) tick();
        check("t4_phase_held", sample, 147);
        // Restart, then a stop request withdrawn at cnt=200 must not disturb anything.
        en = 1'b1;
        tick();
        check("t4_restart_ps", period_start, 1);
        hi      = 0;
        busy_lo = 0;
        for (int i = 0; i < 256; i++) begin
            hi += int'(pwm_out);
            busy_lo += int'(!busy);
            if (i == 100) en = 1'b0;
            if (i == 200) en = 1'b1;
            tick();
        end
        check("t4_rearm_hi", hi, 147);
        check("t4_rearm_busy_gap", busy_lo, 0);
        check("t4_rearm_ps", period_start, 1);
        measure(hi, smp);
        check("t4_next_hi", hi, 147);
        check("t4_next_smp", smp, 159);

        // Asynchronous reset at cnt=50 while pwm_out is high.
        repeat (50) tick();
        check("t5_pre_pwm", pwm_out, 1);
        #2 rst = 1'b0;
        #1;
        check("t5_async_pwm", pwm_out, 0);
        check("t5_async_sample", sample, 128);
        check("t5_async_busy", busy, 0);
        @(negedge pwm_clk);
        rst = 1'b1;
        tick();
        check("t5_restart_ps", period_start, 1);
        check("t5_restart_no_ack", ftw_ack, 0);
        measure(hi, smp);
        // Duty was captured from the reset value of sample. Phase restarts at 0.
        check("t5_hi_p1", hi, 128);
        check("t5_smp_p1", smp, 134);
        measure(hi, smp);
        check("t5_hi_p2", hi, 134);

`ifdef SIN_PWM_COMPL_EN
        // Complementary outputs with duty=134: each output loses DEAD cycles after its rising edge.
        begin
            int hi_p;
            int hi_n;
            int both;
            hi_p = 0;
            hi_n = 0;
            both = 0;
            for (int i = 0; i < 256; i++) begin
                hi_p += int'(pwm_out);
                hi_n += int'(pwm_out_n);
                both += int'(pwm_out && pwm_out_n);
                tick();
            end
            check("t6_hi_p", hi_p, 134 - DEAD);
            check("t6_hi_n", hi_n, 256 - 134 - DEAD);
            check("t6_overlap", both, 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
